// File: rtl/key_note_encoder_if.sv
// Key/note bundle between board keys, encoder and the tone/display path.
interface key_note_encoder_if;
  logic [6:0] keys;
  logic [2:0] note;
  logic       note_change;
  logic [6:0] held;

  modport master (
    input  keys,
    output note,
    output note_change,
    output held
  );

  modport slave (
    output keys,
    input  note,
    input  note_change,
    input  held
  );
endinterface

// File: rtl/key_note_encoder.sv
// Seven-key sync/debounce front end producing the 3-bit note code.
// Define LAST_PRESS_EN for last-press priority instead of lowest-index.
module key_note_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  key_note_encoder_if.master bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [6:0]       sync1_q;
  logic [6:0]       sync2_q;
  logic [6:0]       stable_q;
  logic [6:0]       stable_d;
  logic [CNT_W-1:0] cnt_q [7];
  logic [CNT_W-1:0] cnt_d [7];
  logic [2:0]       note_q;
  logic [2:0]       note_d;
  logic             chg_q;
  logic             chg_d;
  logic [2:0]       sel;

  function automatic logic [2:0] lowest(input logic [6:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) r = 3'(i + 1);
    end
    return r;
  endfunction

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 7; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) stable_d[i] = sync2_q[i];
        else                    cnt_d[i]    = cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef LAST_PRESS_EN
  logic [2:0] last_q;
  logic [2:0] last_d;
  logic [6:0] press;
  logic [6:0] rel;

  // Only the release of the current winner moves the selection.
  always_comb begin
    press  = stable_d & ~stable_q;
    rel    = stable_q & ~stable_d;
    last_d = last_q;
    if (|press) begin
      last_d = lowest(press);
    end else if (last_q != 3'd0) begin
      if (rel[last_q - 3'd1]) last_d = lowest(stable_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 3'd0;
    else        last_q <= last_d;
  end

  assign sel = last_q;
`else
  assign sel = lowest(stable_q);
`endif

  assign note_d = sel;
  assign chg_d  = (sel != note_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      note_q   <= '0;
      chg_q    <= 1'b0;
      for (int i = 0; i < 7; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= bus.keys;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      note_q   <= note_d;
      chg_q    <= chg_d;
      for (int i = 0; i < 7; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.held        = stable_q;
  assign bus.note        = note_q;
  assign bus.note_change = chg_q;

endmodule
